regfile_sb: RTL and testbench

Parametrised synchronous-read register file with byte-enable writes, a hardwired-zero option and a per-register pending-write scoreboard. It replaces the fixed 32x32 two-read/one-write file in the CPU datapath, feeding operand reads to the decode/issue stage. It flags operands whose producing write is still outstanding, so issue logic can stall.

---
 rtl/regfile_sb.sv | 161 ++++++++++++++++
 tb/tb_regfile_sb.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two synchronous read ports,
// one byte-enable write port and a per-register pending-write scoreboard.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a read captured at the same edge as a write/issue sees the
//               post-edge data (byte-merged) and post-edge scoreboard bit.
//   undefined : a same-edge read sees the pre-edge register and scoreboard.
//
// Parameters:
//   DATA_W   register width in bits (multiple of 8)
//   ADDR_W   address width, depth = 2**ADDR_W
//   ZERO_REG 1 = register 0 is hardwired to zero and never marked busy
//
// Ports:
//   Clk, Rst_n                  clock, asynchronous active-low reset
//   WriteData/WriteAddress      write payload and destination
//   RegWriteEn, WriteByteEn     write strobe and per-byte mask
//   IssueEn, IssueAddress       marks a destination register as pending
//   ReadEn, ReadAddress1/2      read capture strobe and operand addresses
//   ReadData1/2, Busy1/2        registered operand data and pending bits
//   ReadValid                   high the cycle after a ReadEn capture
module regfile_sb #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic [DATA_W-1:0]   WriteData,
  input  logic [ADDR_W-1:0]   WriteAddress,
  input  logic                RegWriteEn,
  input  logic [DATA_W/8-1:0] WriteByteEn,
  input  logic                IssueEn,
  input  logic [ADDR_W-1:0]   IssueAddress,
  input  logic                ReadEn,
  input  logic [ADDR_W-1:0]   ReadAddress1,
  input  logic [ADDR_W-1:0]   ReadAddress2,
  output logic [DATA_W-1:0]   ReadData1,
  output logic [DATA_W-1:0]   ReadData2,
  output logic                Busy1,
  output logic                Busy2,
  output logic                ReadValid
);

  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int unsigned NBYTES = DATA_W / 8;
  localparam int unsigned NPORTS = 2;

  // Storage and scoreboard
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_sb;

  // Registered read outputs
  logic [DATA_W-1:0] r_rd_data1;
  logic [DATA_W-1:0] r_rd_data2;
  logic              r_busy1;
  logic              r_busy2;
  logic              r_rd_valid;

  // Qualified strobes, merged write word, next scoreboard, read lookups
  logic              w_wr_ok;
  logic              w_iss_ok;
  logic [DATA_W-1:0] w_wr_merged;
  logic [DEPTH-1:0]  w_sb_next;
  logic [ADDR_W-1:0] w_rd_addr [NPORTS];
  logic [DATA_W-1:0] w_rd_data [NPORTS];
  logic              w_rd_busy [NPORTS];

  // Address 0 is inert for writes and issues when hardwired to zero
  always_comb begin
    w_wr_ok  = RegWriteEn && !(ZERO_REG && (WriteAddress == '0));
    w_iss_ok = IssueEn    && !(ZERO_REG && (IssueAddress == '0));
  end

  // New word for the write target: masked bytes replaced, others kept
  always_comb begin
    w_wr_merged = r_mem[WriteAddress];
    for (int i = 0; i < int'(NBYTES); i++) begin
      if (WriteByteEn[i]) begin
        w_wr_merged[8*i +: 8] = WriteData[8*i +: 8];
      end
    end
  end

  // Write clears pending, issue sets it; the set is applied last so it wins
  always_comb begin
    w_sb_next = r_sb;
    if (w_wr_ok) begin
      w_sb_next[WriteAddress] = 1'b0;
    end
    if (w_iss_ok) begin
      w_sb_next[IssueAddress] = 1'b1;
    end
  end

  always_comb begin
    w_rd_addr[0] = ReadAddress1;
    w_rd_addr[1] = ReadAddress2;
  end

  // Per-port operand lookup, including optional same-edge forwarding
  always_comb begin
    for (int p = 0; p < int'(NPORTS); p++) begin
      w_rd_data[p] = r_mem[w_rd_addr[p]];
      w_rd_busy[p] = r_sb[w_rd_addr[p]];
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (w_rd_addr[p] == WriteAddress)) begin
        w_rd_data[p] = w_wr_merged;
      end
      w_rd_busy[p] = w_sb_next[w_rd_addr[p]];
`else
`endif
      // Hardwired zero overrides any forwarding
      if (ZERO_REG && (w_rd_addr[p] == '0)) begin
        w_rd_data[p] = '0;
        w_rd_busy[p] = 1'b0;
      end
    end
  end

  // Register array and scoreboard state
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
      r_sb <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[WriteAddress] <= w_wr_merged;
      end
      r_sb <= w_sb_next;
    end
  end

  // Read capture; outputs hold when ReadEn is low
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rd_data1 <= '0;
      r_rd_data2 <= '0;
      r_busy1    <= 1'b0;
      r_busy2    <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= ReadEn;
      if (ReadEn) begin
        r_rd_data1 <= w_rd_data[0];
        r_rd_data2 <= w_rd_data[1];
        r_busy1    <= w_rd_busy[0];
        r_busy2    <= w_rd_busy[1];
      end
    end
  end

  assign ReadData1 = r_rd_data1;
  assign ReadData2 = r_rd_data2;
  assign Busy1     = r_busy1;
  assign Busy2     = r_busy2;
  assign ReadValid = r_rd_valid;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: expected read results are queued when a
// read is driven and popped when ReadValid appears one cycle later.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        Clk;
  logic        Rst_n;
  logic [31:0] WriteData;
  logic [4:0]  WriteAddress;
  logic        RegWriteEn;
  logic [3:0]  WriteByteEn;
  logic        IssueEn;
  logic [4:0]  IssueAddress;
  logic        ReadEn;
  logic [4:0]  ReadAddress1;
  logic [4:0]  ReadAddress2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Busy1;
  logic        Busy2;
  logic        ReadValid;

  typedef struct packed {
    logic [31:0] d1;
    logic [31:0] d2;
    logic        b1;
    logic        b2;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          failures;
  logic [31:0] last_d1;
  logic [31:0] last_d2;
  logic        last_b1;
  logic        last_b2;

  regfile_sb dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .WriteData    (WriteData),
    .WriteAddress (WriteAddress),
    .RegWriteEn   (RegWriteEn),
    .WriteByteEn  (WriteByteEn),
    .IssueEn      (IssueEn),
    .IssueAddress (IssueAddress),
    .ReadEn       (ReadEn),
    .ReadAddress1 (ReadAddress1),
    .ReadAddress2 (ReadAddress2),
    .ReadData1    (ReadData1),
    .ReadData2    (ReadData2),
    .Busy1        (Busy1),
    .Busy2        (Busy2),
    .ReadValid    (ReadValid)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    RegWriteEn   = 1'b1;
    WriteAddress = a;
    WriteData    = d;
    WriteByteEn  = be;
  endtask

  task automatic set_issue(input logic [4:0] a);
    IssueEn      = 1'b1;
    IssueAddress = a;
  endtask

  task automatic set_read(input logic [4:0] a1, input logic [4:0] a2,
                          input logic [31:0] d1, input logic [31:0] d2,
                          input logic b1, input logic b2);
    exp_t e;
    ReadEn       = 1'b1;
    ReadAddress1 = a1;
    ReadAddress2 = a2;
    e.d1 = d1; e.d2 = d2; e.b1 = b1; e.b2 = b2;
    exp_q.push_back(e);
  endtask

  task automatic clear_strobes();
    RegWriteEn  = 1'b0;
    IssueEn     = 1'b0;
    ReadEn      = 1'b0;
    WriteByteEn = 4'h0;
  endtask

  // One clock: sample #1 after the edge, check capture or hold, drop strobes
  task automatic tick();
    logic rd_flag;
    exp_t e;
    rd_flag = ReadEn;
    @(posedge Clk);
    #1;
    chk("read_valid", 32'(ReadValid), 32'(rd_flag));
    if (rd_flag) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        failures++;
        $error("FAIL queue_underflow observed=%0d expected=%0d", 0, 1);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rd_data1", ReadData1, e.d1);
        chk("rd_data2", ReadData2, e.d2);
        chk("busy1", 32'(Busy1), 32'(e.b1));
        chk("busy2", 32'(Busy2), 32'(e.b2));
        last_d1 = e.d1; last_d2 = e.d2; last_b1 = e.b1; last_b2 = e.b2;
      end
    end else begin
      chk("hold_data1", ReadData1, last_d1);
      chk("hold_data2", ReadData2, last_d2);
      chk("hold_busy1", 32'(Busy1), 32'(last_b1));
      chk("hold_busy2", 32'(Busy2), 32'(last_b2));
    end
    clear_strobes();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data1"}, ReadData1, 32'h0);
    chk({tag, "_data2"}, ReadData2, 32'h0);
    chk({tag, "_busy1"}, 32'(Busy1), 32'h0);
    chk({tag, "_busy2"}, 32'(Busy2), 32'h0);
    chk({tag, "_valid"}, 32'(ReadValid), 32'h0);
  endtask

  initial begin
    checks = 0; failures = 0;
    last_d1 = '0; last_d2 = '0; last_b1 = 1'b0; last_b2 = 1'b0;
    WriteData = '0; WriteAddress = '0; IssueAddress = '0;
    ReadAddress1 = '0; ReadAddress2 = '0;
    clear_strobes();

    // Power-on reset
    Rst_n = 1'b1;
    #1 Rst_n = 1'b0;
    #3;
    chk_all_zero("por");
    @(posedge Clk); @(posedge Clk); #1;
    chk_all_zero("por_hold");
    Rst_n = 1'b1;

    // Fresh file reads zero, not busy
    set_read(5'd3, 5'd31, 32'h0, 32'h0, 1'b0, 1'b0); tick();

    // Byte-masked partial overwrite
    set_write(5'd5, 32'hDEADBEEF, 4'hF); tick();
    set_write(5'd5, 32'h00001234, 4'h3); tick();
    set_read(5'd5, 5'd5, 32'hDEAD1234, 32'hDEAD1234, 1'b0, 1'b0); tick();

    // Issue marks busy, write clears it
    set_issue(5'd7); tick();
    set_read(5'd7, 5'd7, 32'h0, 32'h0, 1'b1, 1'b1); tick();
    set_write(5'd7, 32'h00000055, 4'hF); tick();
    set_read(5'd7, 5'd5, 32'h55, 32'hDEAD1234, 1'b0, 1'b0); tick();

    // Same-edge write and read
    set_write(5'd9, 32'hA5A5A5A5, 4'hF);
    set_read(5'd9, 5'd5, BYP ? 32'hA5A5A5A5 : 32'h0, 32'hDEAD1234, 1'b0, 1'b0); tick();
    set_read(5'd9, 5'd9, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 1'b0); tick();

    // Same-edge issue and read
    set_issue(5'd10);
    set_read(5'd10, 5'd9, 32'h0, 32'hA5A5A5A5, BYP, 1'b0); tick();
    set_read(5'd10, 5'd10, 32'h0, 32'h0, 1'b1, 1'b1); tick();

    // Same-edge single-byte write: forwarded value is byte-merged
    set_write(5'd5, 32'h11223344, 4'h8);
    set_read(5'd5, 5'd7, BYP ? 32'h11AD1234 : 32'hDEAD1234, 32'h55, 1'b0, 1'b0); tick();
    set_read(5'd5, 5'd5, 32'h11AD1234, 32'h11AD1234, 1'b0, 1'b0); tick();

    // Empty byte mask still clears busy but leaves data alone
    set_write(5'd10, 32'h00000077, 4'h0);
    set_read(5'd10, 5'd10, 32'h0, 32'h0, !BYP, !BYP); tick();
    set_read(5'd10, 5'd10, 32'h0, 32'h0, 1'b0, 1'b0); tick();

    // Issue and write same edge: set wins, data still stored
    set_write(5'd12, 32'hCAFEF00D, 4'hF);
    set_issue(5'd12); tick();
    set_read(5'd12, 5'd12, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1, 1'b1); tick();

    // Hardwired zero ignores write and issue
    set_write(5'd0, 32'hFFFFFFFF, 4'hF);
    set_issue(5'd0);
    set_read(5'd0, 5'd12, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1); tick();
    set_read(5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 1'b0); tick();

    // Idle cycle: outputs hold, ReadValid low
    tick();

    // Load nonzero outputs, then reset mid-cycle with a capture pending
    set_read(5'd5, 5'd12, 32'h11AD1234, 32'hCAFEF00D, 1'b0, 1'b1); tick();
    ReadEn = 1'b1; ReadAddress1 = 5'd7; ReadAddress2 = 5'd9;
    #2 Rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    clear_strobes();
    last_d1 = '0; last_d2 = '0; last_b1 = 1'b0; last_b2 = 1'b0;
    @(posedge Clk); #1;
    chk_all_zero("rst_hold");
    Rst_n = 1'b1;

    // Everything cleared
    set_read(5'd5, 5'd12, 32'h0, 32'h0, 1'b0, 1'b0); tick();
    set_read(5'd7, 5'd9, 32'h0, 32'h0, 1'b0, 1'b0); tick();
    set_read(5'd10, 5'd31, 32'h0, 32'h0, 1'b0, 1'b0); tick();

    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
